// File: rtl/dmem_pkg.sv
// Shared codes, FSM states and lane helpers for the data-memory controller.
// Lanes are big-endian: byte offset 0 lives in bits [31:24].
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_RSVD = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_ALIGN    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_RAM, ST_MMIO_WAIT, ST_RESP} state_t;

  // Reserved size is reported as an alignment error.
  function automatic logic misaligned(logic [1:0] size, logic [1:0] off);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = off[0];
      SIZE_WORD: misaligned = |off;
      default:   misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(logic [1:0] size, logic [1:0] off);
    case (size)
      SIZE_BYTE: lane_be = 4'b1000 >> off;
      SIZE_HALF: lane_be = off[1] ? 4'b0011 : 4'b1100;
      SIZE_WORD: lane_be = 4'b1111;
      default:   lane_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(logic [1:0] size, logic [31:0] wd);
    case (size)
      SIZE_BYTE: store_lanes = {4{wd[7:0]}};
      SIZE_HALF: store_lanes = {2{wd[15:0]}};
      default:   store_lanes = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(logic [31:0] data, logic [1:0] size,
                                           logic [1:0] off, logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = data[31:24];
      2'd1:    b = data[23:16];
      2'd2:    b = data[15:8];
      default: b = data[7:0];
    endcase
    h = off[1] ? data[15:0] : data[31:16];
    case (size)
      SIZE_BYTE: load_ext = {{24{sgn & b[7]}}, b};
      SIZE_HALF: load_ext = {{16{sgn & h[15]}}, h};
      default:   load_ext = data;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Core-side request/response bus plus the waited MMIO port of the data-memory controller.
// master = core + peripherals, slave = controller.
interface data_memory_ctrl_if;
  logic        req_in;
  logic        we_in;
  logic [31:0] addr_in;
  logic [1:0]  size_in;
  logic        signed_in;
  logic [31:0] writedata_in;
  logic        ready_out;
  logic        valid_out;
  logic [31:0] readdata_out;
  logic [1:0]  error_out;
  logic        mmio_req_out;
  logic        mmio_we_out;
  logic [15:0] mmio_addr_out;
  logic [3:0]  mmio_be_out;
  logic [31:0] mmio_wdata_out;
  logic        mmio_ack_in;
  logic [31:0] mmio_rdata_in;

  modport master (
    output req_in, we_in, addr_in, size_in, signed_in, writedata_in, mmio_ack_in, mmio_rdata_in,
    input  ready_out, valid_out, readdata_out, error_out,
           mmio_req_out, mmio_we_out, mmio_addr_out, mmio_be_out, mmio_wdata_out
  );

  modport slave (
    input  req_in, we_in, addr_in, size_in, signed_in, writedata_in, mmio_ack_in, mmio_rdata_in,
    output ready_out, valid_out, readdata_out, error_out,
           mmio_req_out, mmio_we_out, mmio_addr_out, mmio_be_out, mmio_wdata_out
  );
endinterface

// File: rtl/dmem_bank.sv
// Synchronous single-port 32-bit RAM with per-byte write enables (bit3 = bits[31:24]).
module dmem_bank #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clock) begin
    if (we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Data-memory controller: region decode, request FSM, MMIO timeout and load lane/extend.
// RAM loads read at the accept edge so data is ready in the single RAM response cycle.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int                        NUM_REGIONS  = 2,
  parameter logic [16*NUM_REGIONS-1:0] REGION_BASE  = {16'h7fff, 16'h1000},
  parameter int                        DEPTH_LOG2   = 10,
  parameter logic [15:0]               MMIO_BASE    = 16'hffff,
  parameter int                        MMIO_TIMEOUT = 15
) (
  input logic               clock,
  input logic               reset,
  data_memory_ctrl_if.slave bus
);

  localparam logic [7:0] TMO = 8'(MMIO_TIMEOUT);

  state_t state, nxt;

  logic                          acc, hit, mmio_hit, bad, valid, in_mmio, ack, tmo;
  logic [1:0]                    sel, sel_q, size_q, err_q, err_h, dec_err;
  logic [15:0]                   a_q;
  logic                          we_q, sgn_q;
  logic [31:0]                   wd_q, rsp_q, rd_h, cur_rd, bank_mux;
  logic [7:0]                    cnt;
  logic [3:0]                    be_q;
  logic [DEPTH_LOG2-1:0]         bank_idx;
  logic [NUM_REGIONS-1:0][31:0]  bank_rdata;

  // Walk downwards so the lowest matching region wins; RAM beats the MMIO window.
  always_comb begin
    hit = 1'b0;
    sel = 2'd0;
    for (int i = NUM_REGIONS-1; i >= 0; i--)
      if (bus.addr_in[31:16] == REGION_BASE[16*i +: 16]) begin
        hit = 1'b1;
        sel = 2'(i);
      end
  end

  assign mmio_hit = bus.addr_in[31:16] == MMIO_BASE;
  assign bad      = misaligned(bus.size_in, bus.addr_in[1:0]);
  assign dec_err  = bad ? ERR_ALIGN : (hit || mmio_hit) ? ERR_OK : ERR_UNMAPPED;
  assign acc      = bus.req_in && (state == ST_IDLE);
  assign in_mmio  = state == ST_MMIO_WAIT;
  assign ack      = bus.mmio_ack_in;
  assign tmo      = cnt == TMO;
  assign valid    = (state == ST_RAM) || (state == ST_RESP);

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= ST_IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:
        if (acc) begin
          if (bad)           nxt = ST_RESP;
          else if (hit)      nxt = ST_RAM;
          else if (mmio_hit) nxt = ST_MMIO_WAIT;
          else               nxt = ST_RESP;
        end
      ST_RAM:       nxt = ST_IDLE;
      ST_MMIO_WAIT: if (ack || tmo) nxt = ST_RESP;
      ST_RESP:      nxt = ST_IDLE;
      default:      nxt = ST_IDLE;
    endcase
  end

  // cnt counts wait cycles from 1, so the timeout fires on the MMIO_TIMEOUT-th one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      we_q   <= 1'b0;
      size_q <= '0;
      sgn_q  <= 1'b0;
      wd_q   <= '0;
      sel_q  <= '0;
      err_q  <= ERR_OK;
      cnt    <= '0;
      rsp_q  <= '0;
      rd_h   <= '0;
      err_h  <= ERR_OK;
    end else begin
      if (acc) begin
        a_q    <= bus.addr_in[15:0];
        we_q   <= bus.we_in;
        size_q <= bus.size_in;
        sgn_q  <= bus.signed_in;
        wd_q   <= store_lanes(bus.size_in, bus.writedata_in);
        sel_q  <= sel;
        err_q  <= dec_err;
        cnt    <= 8'd1;
        rsp_q  <= '0;
      end else if (in_mmio) begin
        cnt <= cnt + 8'd1;
        if (ack)
          rsp_q <= we_q ? '0 : load_ext(bus.mmio_rdata_in, size_q, a_q[1:0], sgn_q);
        else if (tmo)
          err_q <= ERR_TIMEOUT;
      end
      if (valid) begin
        rd_h  <= cur_rd;
        err_h <= err_q;
      end
    end
  end

  always_comb begin
    bank_mux = '0;
    for (int i = 0; i < NUM_REGIONS; i++)
      if (sel_q == 2'(i)) bank_mux = bank_rdata[i];
  end

  assign bank_idx = (state == ST_IDLE) ? bus.addr_in[DEPTH_LOG2+1:2] : a_q[DEPTH_LOG2+1:2];
  assign be_q     = lane_be(size_q, a_q[1:0]);
  assign cur_rd   = (state == ST_RAM) ? (we_q ? '0 : load_ext(bank_mux, size_q, a_q[1:0], sgn_q))
                                      : rsp_q;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_bank
    dmem_bank #(.DEPTH_LOG2(DEPTH_LOG2)) u_bank (
      .clock (clock),
      .we    ((state == ST_RAM) && we_q && (sel_q == 2'(g))),
      .be    (be_q),
      .addr  (bank_idx),
      .wdata (wd_q),
      .rdata (bank_rdata[g])
    );
  end

  assign bus.ready_out      = state == ST_IDLE;
  assign bus.valid_out      = valid;
  assign bus.readdata_out   = valid ? cur_rd : rd_h;
  assign bus.error_out      = valid ? err_q : err_h;
  assign bus.mmio_req_out   = in_mmio;
  assign bus.mmio_we_out    = in_mmio && we_q;
  assign bus.mmio_addr_out  = in_mmio ? a_q : '0;
  assign bus.mmio_be_out    = in_mmio ? be_q : '0;
  assign bus.mmio_wdata_out = (in_mmio && we_q) ? wd_q : '0;

endmodule
